mdu_iter: RTL



---
 rtl/osyrys64_pkg.sv | 46 ++++
 rtl/mdu_operand_prep.sv | 64 ++++++
 rtl/mdu_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/osyrys64_pkg.sv
// Shared opcode/state types and small decode helpers for the iterative multiply/divide unit.
package osyrys64_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    localparam int WORD_N = 32;

    function automatic logic is_word_op(input mdu_op_e op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem_op(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic [63:0] sext_w(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Combinational operand conditioning: opcode legalisation, W extraction/extension,
// magnitudes, result sign flags and divide special-case detection.
module mdu_operand_prep
    import osyrys64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [3:0]      op_norm,
    output logic [XLEN-1:0] mag1,
    output logic [XLEN-1:0] mag2,
    output logic            neg_q,
    output logic            neg_r,
    output logic            special,
    output logic [XLEN-1:0] special_result
);

    mdu_op_e         op_n;
    logic            word, signed1, signed2, n1, n2, div_zero, div_ovf;
    logic [XLEN-1:0] a, b, src1_w;

    always_comb begin
        op_n = OP_MUL;
        // Unused encodings, and W ops on a 32-bit datapath, fall back to MUL.
        if (op <= 4'd12 && !(XLEN == 32 && is_word_op(mdu_op_e'(op))))
            op_n = mdu_op_e'(op);

        word    = is_word_op(op_n);
        signed1 = op_n inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        signed2 = op_n inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        src1_w  = XLEN'(sext_w(src1[31:0]));

        a = src1;
        b = src2;
        if (word) begin
            a = signed1 ? src1_w : XLEN'({32'd0, src1[31:0]});
            b = signed2 ? XLEN'(sext_w(src2[31:0])) : XLEN'({32'd0, src2[31:0]});
        end

        n1   = signed1 & a[XLEN-1];
        n2   = signed2 & b[XLEN-1];
        mag1 = n1 ? -a : a;
        mag2 = n2 ? -b : b;

        neg_q = n1 ^ n2;
        neg_r = n1;

        div_zero = word ? (src2[31:0] == 32'd0) : (src2 == '0);
        div_ovf  = signed2 && (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                                    : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
        special  = is_div_op(op_n) && (div_zero || div_ovf);

        special_result = '0;
        if (div_zero)
            special_result = is_rem_op(op_n) ? (word ? src1_w : src1) : '1;
        else if (div_ovf)
            special_result = is_rem_op(op_n) ? '0 : (word ? src1_w : src1);

        op_norm = op_n;
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide: one bit per cycle shift-add multiply and restoring divide,
// valid/ready on both sides, early-out for divide special cases, synchronous flush.
module mdu_iter
    import osyrys64_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int W2 = 2 * XLEN;

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    mdu_state_e      state, state_n;
    mdu_op_e         op_q;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]   acc, mcand;
    logic [XLEN-1:0] mplier, result_q;
    logic            neg_q_q, neg_r_q, accept;

    logic [3:0]      p_op;
    logic [XLEN-1:0] p_mag1, p_mag2, p_special_result;
    logic            p_neg_q, p_neg_r, p_special, p_word, p_div;

    mdu_operand_prep #(.XLEN(XLEN)) u_prep (
        .op             (op),
        .src1           (src1),
        .src2           (src2),
        .op_norm        (p_op),
        .mag1           (p_mag1),
        .mag2           (p_mag2),
        .neg_q          (p_neg_q),
        .neg_r          (p_neg_r),
        .special        (p_special),
        .special_result (p_special_result)
    );

    assign p_word = is_word_op(mdu_op_e'(p_op));
    assign p_div  = is_div_op(mdu_op_e'(p_op));
    assign accept = in_valid && in_ready;
    assign result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = (state == ST_IDLE) && !flush;
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (accept) state_n = p_special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == CNT_W'(1)) state_n = ST_FIX;
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_IDLE;
    end

    // Divide step: acc holds {remainder, dividend/quotient}; mcand low half holds the divisor.
    logic [XLEN:0]   wide, dsub;
    logic            ge;
    logic [XLEN-1:0] rem_n;
    logic [W2-1:0]   div_next;

    always_comb begin
        wide     = {acc[W2-1:XLEN], acc[XLEN-1]};
        dsub     = wide - {1'b0, mcand[XLEN-1:0]};
        ge       = wide >= {1'b0, mcand[XLEN-1:0]};
        rem_n    = ge ? dsub[XLEN-1:0] : wide[XLEN-1:0];
        div_next = {rem_n, acc[XLEN-2:0], ge};
    end

    logic [W2-1:0]   prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_result;

    always_comb begin
        prod_s = neg_q_q ? -acc : acc;
        quo_s  = neg_q_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s  = neg_r_q ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[W2-1:XLEN];
            OP_MULW:                      fix_result = XLEN'(sext_w(acc[31:0]));
            OP_DIV, OP_DIVU:              fix_result = quo_s;
            OP_REM, OP_REMU:              fix_result = rem_s;
            OP_DIVW, OP_DIVUW:            fix_result = XLEN'(sext_w(quo_s[31:0]));
            OP_REMW, OP_REMUW:            fix_result = XLEN'(sext_w(rem_s[31:0]));
            default:                      fix_result = acc[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result_q <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else if (accept) begin
            op_q    <= mdu_op_e'(p_op);
            neg_q_q <= p_neg_q;
            neg_r_q <= p_neg_r;
            cnt     <= p_word ? CNT_W'(WORD_N) : CNT_W'(XLEN);
            if (p_special) result_q <= p_special_result;
            if (p_div) begin
                // W dividends are pre-aligned so only 32 steps are needed.
                acc   <= {{XLEN{1'b0}}, p_word ? (p_mag1 << (XLEN - WORD_N)) : p_mag1};
                mcand <= {{XLEN{1'b0}}, p_mag2};
            end else begin
                acc   <= '0;
                mcand <= {{XLEN{1'b0}}, p_mag1};
            end
            mplier <= p_mag2;
        end else if (state == ST_CALC && !flush) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div_op(op_q)) begin
                acc <= div_next;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end else if (state == ST_FIX && !flush) begin
            result_q <= fix_result;
        end
    end

endmodule
